// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: start-bit validation, LSB-first deserialisation, stop-bit framing check.
// Optional even-parity stage is enabled by defining RX_PARITY_EN.
module uart_rx #(
  parameter int WIDTH_WORD    = 8,
  parameter int CANT_BIT_STOP = 2,
  parameter int TICKS_PER_BIT = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_tick,
  input  logic                  i_bit_rx,
  output logic [WIDTH_WORD-1:0] o_data,
  output logic                  o_rx_done,
  output logic                  o_frame_error,
  output logic                  o_parity_error
);

  localparam int BW = $clog2(WIDTH_WORD) + 1;
  localparam logic [3:0]    TICK_MID  = 4'(TICKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    TICK_END  = 4'(TICKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(WIDTH_WORD);
  localparam logic [BW-1:0] LAST_STOP = BW'(CANT_BIT_STOP);

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                state_q, state_d;
  logic                  sync1_q, sync2_q;
  logic [3:0]            tick_q, tick_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [WIDTH_WORD-1:0] shift_q, shift_d;
  logic                  flag_q, flag_d;
  logic [WIDTH_WORD-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  ferr_q, ferr_d;
`ifdef RX_PARITY_EN
  logic                  par_q, par_d;
  logic                  perr_q, perr_d;
`endif
  logic                  line;

  assign line = sync2_q;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      flag_q  <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync1_q <= i_bit_rx;
      sync2_q <= sync1_q;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      flag_q  <= flag_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    flag_d  = flag_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
`ifdef RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!line) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START: begin
        if (i_tick) begin
          if (tick_q == TICK_MID) begin
            if (line) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              tick_d  = '0;
              bit_d   = '0;
              flag_d  = 1'b0;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          if (tick_q == TICK_END) begin
            tick_d  = '0;
            shift_d = {line, shift_q[WIDTH_WORD-1:1]};
            bit_d   = bit_q + 1'b1;
            // bit counter is reused to count stop bits, so clear it on the way out
            if (bit_d == LAST_DATA) begin
              bit_d   = '0;
`ifdef RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
`ifdef RX_PARITY_EN
      PARITY: begin
        if (i_tick) begin
          if (tick_q == TICK_END) begin
            tick_d  = '0;
            par_d   = line;
            state_d = STOP;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
`endif
      STOP: begin
        if (i_tick) begin
          if (tick_q == TICK_END) begin
            tick_d = '0;
            flag_d = flag_q | ~line;
            bit_d  = bit_q + 1'b1;
            if (bit_d == LAST_STOP) begin
              state_d = IDLE;
              bit_d   = '0;
              data_d  = shift_q;
              ferr_d  = flag_q | ~line;
              done_d  = 1'b1;
`ifdef RX_PARITY_EN
              perr_d  = ^{shift_q, par_q};
`endif
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_data        = data_q;
  assign o_rx_done     = done_q;
  assign o_frame_error = ferr_q;
`ifdef RX_PARITY_EN
  assign o_parity_error = perr_q;
`else
  assign o_parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table vectors, corner-case sequences and random frames
// checked against a frame-decoding reference model.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;
`ifdef RX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] o_data;
  logic       o_rx_done, o_frame_error, o_parity_error;

  uart_rx #(.WIDTH_WORD(8), .CANT_BIT_STOP(2), .TICKS_PER_BIT(16)) dut (
    .i_clock        (clk),
    .i_reset        (rst_n),
    .i_tick         (tick),
    .i_bit_rx       (rx),
    .o_data         (o_data),
    .o_rx_done      (o_rx_done),
    .o_frame_error  (o_frame_error),
    .o_parity_error (o_parity_error)
  );

  always #5 clk = ~clk;

  int unsigned tick_div = 0;
  always @(negedge clk) begin
    tick_div = (tick_div + 1) % 4;
    tick     = (tick_div == 0);
  end

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } rec_t;

  typedef logic bitq_t[$];

  int   checks = 0;
  int   errors = 0;
  rec_t got_q[$];
  int   done_cnt = 0;
  int   long_pulse = 0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (o_rx_done) begin
      got_q.push_back('{o_data, o_frame_error, o_parity_error});
      done_cnt++;
      if (prev_done) long_pulse++;
    end
    prev_done = o_rx_done;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bitq_t build_frame(input logic [7:0] d, input logic s0, input logic pflip);
    bitq_t f;
    f.push_back(1'b0);
    for (int i = 0; i < 8; i++) f.push_back(d[i]);
    if (PAR_EN) f.push_back((^d) ^ pflip);
    f.push_back(s0);
    f.push_back(1'b1);
    return f;
  endfunction

  // Reference: decode a serial frame directly from its bit list.
  function automatic rec_t decode(input bitq_t f);
    rec_t r;
    int   idx;
    for (int i = 0; i < 8; i++) r.data[i] = f[1 + i];
    idx = 9;
    r.perr = 1'b0;
    if (PAR_EN) begin
      r.perr = (^r.data) ^ f[9];
      idx = 10;
    end
    r.ferr = 1'b0;
    for (int i = idx; i < f.size(); i++) if (f[i] == 1'b0) r.ferr = 1'b1;
    return r;
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    rx = b;
    repeat (BIT_CLKS - 1) @(negedge clk);
  endtask

  task automatic send_bits(input bitq_t f);
    foreach (f[i]) send_bit(f[i]);
  endtask

  task automatic expect_rec(input string name, input rec_t e);
    rec_t g;
    int   n = 0;
    while (got_q.size() == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (got_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done pulse, expected one", name);
    end else begin
      g = got_q.pop_front();
      check({name, "_data"}, 32'(g.data), 32'(e.data));
      check({name, "_ferr"}, 32'(g.ferr), 32'(e.ferr));
      check({name, "_perr"}, 32'(g.perr), 32'(e.perr));
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       s0;
    logic       pflip;
    logic [7:0] exp_data;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bitq_t f;
    rec_t  e;
    int    cnt0;
    logic [7:0] d;
    logic  s0, pf;

    tbl[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
    tbl[2] = '{8'h55, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0};
    tbl[3] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[4] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[5] = '{8'h07, 1'b1, 1'b0, 8'h07, 1'b0, 1'b0};
    tbl[6] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, PAR_EN};

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_data", 32'(o_data), 32'h00);
    check("reset_done", 32'(o_rx_done), 32'h0);
    check("reset_ferr", 32'(o_frame_error), 32'h0);
    check("reset_perr", 32'(o_parity_error), 32'h0);
    rst_n = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);

    foreach (tbl[i]) begin
      cnt0 = done_cnt;
      f = build_frame(tbl[i].data, tbl[i].s0, tbl[i].pflip);
      send_bits(f);
      send_bit(1'b1);
      expect_rec($sformatf("vec%0d", i), '{tbl[i].exp_data, tbl[i].exp_ferr, tbl[i].exp_perr});
      check($sformatf("vec%0d_pulses", i), 32'(done_cnt - cnt0), 32'd1);
    end

    // Glitch: 3 ticks low is shorter than the mid-start sample point.
    cnt0 = done_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    check("glitch_pulses", 32'(done_cnt - cnt0), 32'd0);
    check("glitch_data", 32'(o_data), 32'h07);

    // Back-to-back frames with no idle gap.
    cnt0 = done_cnt;
    send_bits(build_frame(8'h00, 1'b1, 1'b0));
    send_bits(build_frame(8'hFF, 1'b1, 1'b0));
    send_bit(1'b1);
    expect_rec("b2b0", '{8'h00, 1'b0, 1'b0});
    expect_rec("b2b1", '{8'hFF, 1'b0, 1'b0});
    check("b2b_pulses", 32'(done_cnt - cnt0), 32'd2);

    // Reset asserted mid data bit 4 of 0x81 and held through the rest of the frame.
    cnt0 = done_cnt;
    d = 8'h81;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    @(negedge clk);
    rx = d[4];
    repeat (32) @(negedge clk);
    rst_n = 1'b0;
    repeat (31) @(negedge clk);
    for (int i = 5; i < 8; i++) send_bit(d[i]);
    if (PAR_EN) send_bit(^d);
    send_bit(1'b1);
    send_bit(1'b1);
    rst_n = 1'b1;
    send_bit(1'b1);
    check("rstmid_pulses", 32'(done_cnt - cnt0), 32'd0);
    check("rstmid_data", 32'(o_data), 32'h00);
    send_bits(build_frame(8'h81, 1'b1, 1'b0));
    send_bit(1'b1);
    expect_rec("rstmid_next", '{8'h81, 1'b0, 1'b0});

    // Random frames against the decoding model.
    for (int n = 0; n < 20; n++) begin
      d  = 8'($urandom_range(0, 255));
      s0 = ($urandom_range(0, 3) != 0);
      pf = 1'($urandom_range(0, 1));
      f  = build_frame(d, s0, pf);
      e  = decode(f);
      send_bits(f);
      repeat ($urandom_range(0, 2)) send_bit(1'b1);
      expect_rec($sformatf("rnd%0d", n), e);
    end
    send_bit(1'b1);

    check("single_cycle_pulses", 32'(long_pulse), 32'd0);
    check("no_extra_pulses", 32'(got_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
